// File: rtl/multi_load_write_back_pkg.sv
// Shared write-back definitions: data/address widths, control signal types and the
// multi-load FSM state type.
package multi_load_write_back_pkg;

    localparam int unsigned WORD       = 32;
    localparam int unsigned ADDR_WIDTH = 4;

    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = 4'd15;

    typedef enum logic {
        FROM_ALU    = 1'b0,
        FROM_MEMORY = 1'b1
    } reg_file_data_source;

    typedef logic reg_file_write_sig;
    typedef logic branch_from_wb;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wb_state_t;

endpackage

// File: rtl/multi_load_write_back_lowest_set_bit_encoder.sv
// Combinational priority encoder: index and one-hot mask of the lowest set bit of vec_i.
module lowest_set_bit_encoder #(
    parameter int unsigned Width = 9,
    parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] vec_i,
    output logic [IdxW-1:0]  idx_o,
    output logic [Width-1:0] onehot_o,
    output logic             none_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = vec_i & (~vec_i + Width'(1));
    assign none_o   = ~|vec_i;

    always_comb begin
        idx_o = '0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/multi_load_write_back.sv
// Registered write-back stage: retires single-result ops and sequences POP/LDM bursts,
// one register per memory beat, branching on the PC beat.
module multi_load_write_back
    import multi_load_write_back_pkg::*;
#(
    parameter int unsigned REG_LIST_W = 9,
    parameter int unsigned PC_BIT     = REG_LIST_W - 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    is_valid_i,
    input  logic                    multi_load_i,
    input  logic [REG_LIST_W-1:0]   reg_list_i,
    input  reg_file_data_source     reg_data_ctrl_sig_i,
    input  reg_file_write_sig       reg_file_write_en_i,
    input  branch_from_wb           branch_from_wb_i,
    input  logic [ADDR_WIDTH-1:0]   reg_dest_addr_i,
    input  logic [WORD-1:0]         alu_result_i,
    input  logic [WORD-1:0]         mem_data_i,
    input  logic                    beat_valid_i,
    input  logic [WORD-1:0]         beat_data_i,
    output reg_file_write_sig       reg_file_write_en_o,
    output logic [WORD-1:0]         reg_data_o,
    output logic [ADDR_WIDTH-1:0]   reg_dest_addr_o,
    output branch_from_wb           branch_from_wb_o,
    output logic [WORD-1:0]         program_counter_o,
    output logic                    stall_o
);

    localparam int unsigned IdxW = (REG_LIST_W > 1) ? $clog2(REG_LIST_W) : 1;

    wb_state_t               state_q, state_d;
    logic [REG_LIST_W-1:0]   list_q, list_d;
    logic                    we_q, we_d;
    logic                    br_q, br_d;
    logic [WORD-1:0]         data_q, data_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD-1:0]         pc_q, pc_d;
    logic                    stall_q, stall_d;

    logic [IdxW-1:0]         sel_idx;
    logic [REG_LIST_W-1:0]   sel_onehot;
    logic                    sel_none;

    lowest_set_bit_encoder #(
        .Width (REG_LIST_W),
        .IdxW  (IdxW)
    ) u_lsb_enc (
        .vec_i    (list_q),
        .idx_o    (sel_idx),
        .onehot_o (sel_onehot),
        .none_o   (sel_none)
    );

    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        we_d    = 1'b0;
        br_d    = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;
        pc_d    = pc_q;

        unique case (state_q)
            IDLE: begin
                if (is_valid_i) begin
                    if (multi_load_i) begin
                        // An empty list retires as a no-op without entering BURST.
                        if (|reg_list_i) begin
                            state_d = BURST;
                            list_d  = reg_list_i;
                        end
                    end else begin
                        we_d   = reg_file_write_en_i;
                        data_d = (reg_data_ctrl_sig_i == FROM_ALU) ? alu_result_i : mem_data_i;
                        addr_d = reg_dest_addr_i;
                        br_d   = branch_from_wb_i;
                        pc_d   = mem_data_i;
                    end
                end
            end
            BURST: begin
                if (beat_valid_i && !sel_none) begin
                    if (sel_idx == IdxW'(PC_BIT)) begin
                        br_d = 1'b1;
                        pc_d = beat_data_i;
                    end else begin
                        we_d   = 1'b1;
                        data_d = beat_data_i;
                        addr_d = ADDR_WIDTH'(sel_idx);
                    end
                    list_d = list_q & ~sel_onehot;
                    if (list_d == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d == BURST);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            list_q  <= '0;
            we_q    <= 1'b0;
            br_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            pc_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            we_q    <= we_d;
            br_q    <= br_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            stall_q <= stall_d;
        end
    end

    assign reg_file_write_en_o = we_q;
    assign reg_data_o          = data_q;
    assign reg_dest_addr_o     = addr_q;
    assign branch_from_wb_o    = br_q;
    assign program_counter_o   = pc_q;
    assign stall_o             = stall_q;

endmodule

// File: tb/tb_multi_load_write_back.sv
// Scoreboard bench: stimulus pushes expected writes/branches, a negedge monitor pops and
// compares every write or branch pulse the DUT presents.
module tb_multi_load_write_back;
    import multi_load_write_back_pkg::*;

    typedef struct {
        logic            is_branch;
        logic [3:0]      addr;
        logic [31:0]     data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                is_valid;
    logic                multi_load;
    logic [8:0]          reg_list;
    reg_file_data_source src;
    logic                we_in;
    logic                br_in;
    logic [3:0]          dest;
    logic [31:0]         alu;
    logic [31:0]         mem;
    logic                beat_valid;
    logic [31:0]         beat_data;
    logic                we_out;
    logic [31:0]         data_out;
    logic [3:0]          addr_out;
    logic                br_out;
    logic [31:0]         pc_out;
    logic                stall;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multi_load_write_back dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .is_valid_i          (is_valid),
        .multi_load_i        (multi_load),
        .reg_list_i          (reg_list),
        .reg_data_ctrl_sig_i (src),
        .reg_file_write_en_i (we_in),
        .branch_from_wb_i    (br_in),
        .reg_dest_addr_i     (dest),
        .alu_result_i        (alu),
        .mem_data_i          (mem),
        .beat_valid_i        (beat_valid),
        .beat_data_i         (beat_data),
        .reg_file_write_en_o (we_out),
        .reg_data_o          (data_out),
        .reg_dest_addr_o     (addr_out),
        .branch_from_wb_o    (br_out),
        .program_counter_o   (pc_out),
        .stall_o             (stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [3:0] a, input logic [31:0] d);
        sb.push_back('{is_branch: 1'b0, addr: a, data: d});
    endtask

    task automatic push_b(input logic [31:0] d);
        sb.push_back('{is_branch: 1'b1, addr: 4'd0, data: d});
    endtask

    // Monitor: every write or branch pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (we_out || br_out) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: we=%0b br=%0b addr=%0d data=0x%0h pc=0x%0h, expected none",
                             we_out, br_out, addr_out, data_out, pc_out);
                end else begin
                    e = sb.pop_front();
                    if (e.is_branch) begin
                        if (!(br_out === 1'b1 && we_out === 1'b0 && pc_out === e.data)) begin
                            n_bad++;
                            $display("FAIL branch_out: br=%0b we=%0b pc=0x%0h, expected br=1 we=0 pc=0x%0h",
                                     br_out, we_out, pc_out, e.data);
                        end
                    end else begin
                        if (!(we_out === 1'b1 && br_out === 1'b0 && addr_out === e.addr &&
                              data_out === e.data)) begin
                            n_bad++;
                            $display("FAIL write_out: we=%0b br=%0b addr=%0d data=0x%0h, expected we=1 br=0 addr=%0d data=0x%0h",
                                     we_out, br_out, addr_out, data_out, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; is_valid = 1'b0; multi_load = 1'b0; reg_list = '0; src = FROM_ALU;
        we_in = 1'b0; br_in = 1'b0; dest = '0; alu = '0; mem = '0;
        beat_valid = 1'b0; beat_data = '0;

        // Reset state
        step(); step();
        check("rst_we", 32'(we_out), 0);
        check("rst_br", 32'(br_out), 0);
        check("rst_data", data_out, 0);
        check("rst_pc", pc_out, 0);
        check("rst_stall", 32'(stall), 0);
        rst_n = 1'b1;
        step();

        // Single op from ALU
        is_valid = 1'b1; src = FROM_ALU; we_in = 1'b1; dest = 4'd3;
        alu = 32'h1234; mem = 32'h5555;
        push_w(4'd3, 32'h1234);
        step();
        check("alu_stall", 32'(stall), 0);

        // Single op from memory
        src = FROM_MEMORY; dest = 4'd5; mem = 32'hCAFE;
        push_w(4'd5, 32'hCAFE);
        step();

        // Single load-branch, no write
        src = FROM_ALU; we_in = 1'b0; br_in = 1'b1; dest = 4'd6; alu = 32'h77; mem = 32'h400;
        push_b(32'h400);
        step();

        // Invalid input: enables low, data/addr/target hold
        is_valid = 1'b0; we_in = 1'b1; br_in = 1'b1; alu = 32'h99; mem = 32'h888; dest = 4'd9;
        step();
        check("inv_we", 32'(we_out), 0);
        check("inv_br", 32'(br_out), 0);
        check("inv_data_hold", data_out, 32'h77);
        check("inv_addr_hold", 32'(addr_out), 6);
        check("inv_pc_hold", pc_out, 32'h400);
        we_in = 1'b0; br_in = 1'b0;

        // Burst without PC: R0, R2
        is_valid = 1'b1; multi_load = 1'b1; reg_list = 9'b0_0000_0101;
        step();
        check("b1_stall_start", 32'(stall), 1);
        is_valid = 1'b0; beat_valid = 1'b1; beat_data = 32'hA;
        push_w(4'd0, 32'hA);
        step();
        check("b1_stall_mid", 32'(stall), 1);
        beat_data = 32'hB;
        push_w(4'd2, 32'hB);
        step();
        check("b1_stall_end", 32'(stall), 0);
        beat_valid = 1'b0;

        // Back-to-back burst with PC and a gap: R1 then branch
        is_valid = 1'b1; reg_list = 9'b1_0000_0010;
        step();
        check("b2_stall_start", 32'(stall), 1);
        is_valid = 1'b0; beat_valid = 1'b1; beat_data = 32'h10;
        push_w(4'd1, 32'h10);
        step();
        check("b2_stall_beat1", 32'(stall), 1);
        beat_valid = 1'b0; beat_data = 32'hDEAD;
        step();
        check("b2_stall_gap", 32'(stall), 1);
        beat_valid = 1'b1; beat_data = 32'h8000;
        push_b(32'h8000);
        step();
        check("b2_stall_end", 32'(stall), 0);
        check("b2_pc", pc_out, 32'h8000);
        beat_valid = 1'b0;

        // Empty list: no-op
        is_valid = 1'b1; reg_list = 9'b0;
        step();
        check("empty_stall", 32'(stall), 0);
        is_valid = 1'b0;
        step();
        check("empty_stall2", 32'(stall), 0);

        // Reset mid-burst
        is_valid = 1'b1; reg_list = 9'b0_1111_0000;
        step();
        check("rb_stall_start", 32'(stall), 1);
        is_valid = 1'b0; multi_load = 1'b0; beat_valid = 1'b1; beat_data = 32'h1;
        push_w(4'd4, 32'h1);
        step();
        rst_n = 1'b0; beat_data = 32'h2;
        step();
        check("rb_we", 32'(we_out), 0);
        check("rb_br", 32'(br_out), 0);
        check("rb_data", data_out, 0);
        check("rb_addr", 32'(addr_out), 0);
        check("rb_pc", pc_out, 0);
        check("rb_stall", 32'(stall), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat_data = 32'h3 + 32'(i);
            step();
            check("rb_post_stall", 32'(stall), 0);
        end
        beat_valid = 1'b0;
        step(); step();

        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
